md_unit_ctrl: RTL and testbench
===============================

// Module: md_unit_ctrl
// PURPOSE
//  Sequencer for the shared multiply/divide resource in the E stage of the 5-stage MIPS pipeline.
//  Accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO command per start pulse and models the multi-cycle latency.
//  Owns the HI/LO registers and raises stall so that D-stage HI/LO-touching instructions wait while busy.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for MULT/MULTU; must be >= 1
//  DIV_CYCLES   10  busy cycles for DIV/DIVU; must be >= 1
// PORTS
//  clk       in   1   clock; all state changes on the rising edge
//  reset     in   1   asynchronous, active-low (0 = reset)
//  start     in   1   one-cycle command strobe from the E stage
//  op        in   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 reserved
//  src_a     in   32  rs operand: dividend / multiplicand / MTHI-MTLO data
//  src_b     in   32  rt operand: divisor / multiplier
//  md_in_d   in   1   D stage holds mult/div/mfhi/mflo/mthi/mtlo
//  busy      out  1   operation in flight
//  stall     out  1   pipeline stall request: md_in_d & (busy | (start & op<=3))
//  hi        out  32  HI register
//  lo        out  32  LO register
// BEHAVIOUR
//  Reset (async assert): state=IDLE, cnt=0, busy=0, hi=0, lo=0, staged results=0. Release is synchronous to clk.
//  FSM states are IDLE and RUN.
//   IDLE, start & op in 0..3: compute the result from src_a/src_b this cycle and store it in hi_nx/lo_nx.
//     Load cnt = MULT_CYCLES (op 0,1) or DIV_CYCLES (op 2,3). Go to RUN. busy=1 from the next cycle.
//   RUN: cnt decrements every cycle. When cnt==1, commit hi<=hi_nx and lo<=lo_nx, clear busy, return to IDLE.
//     busy is high for exactly N cycles. New hi/lo are visible in the cycle busy falls.
//   IDLE, start & op==4 (or 5): hi (or lo) <= src_a at the next edge. No busy, no stall.
//   Any start while in RUN is ignored; the stall rule must prevent it.
//   start with op 6/7 is ignored, with no state change.
//  Arithmetic:
//   MULT: signed 32x32 -> 64; hi = product[63:32], lo = product[31:0].
//   MULTU: same as MULT, unsigned.
//   DIV: lo = quotient truncated toward zero; hi = remainder, sign of dividend.
//   DIVU: unsigned quotient and remainder.
//   DIV 0x80000000 / -1: lo = 0x80000000, hi = 0.
//   Divisor 0: hi and lo are left unchanged, but busy still lasts DIV_CYCLES.
//  stall is combinational with no latency. It covers the start cycle itself, so a back-to-back md op in D waits.
//  hi and lo hold their value while busy; in-flight results are never visible early.
//  Reset asserted mid-operation: the operation is aborted, busy=0 immediately, hi/lo=0.
// TESTING
//  MULT a=3, b=0xFFFFFFFC
//    -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF4.
//  MULTU a=0xFFFFFFFF, b=2
//    -> hi=0x00000001, lo=0xFFFFFFFE after 5 cycles.
//  DIVU 7/2
//    -> busy 10 cycles; lo=3, hi=1.
//  DIV 0xFFFFFFF9/2
//    -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//  DIV x/0 with hi=0x11, lo=0x22 preloaded via MTHI/MTLO
//    -> busy 10 cycles; hi=0x11, lo=0x22 unchanged.
//  MULT start with md_in_d=1 held
//    -> stall=1 from the start cycle through the last busy cycle, 0 the cycle after.
//  A second start during RUN is ignored.
//  Reset pulsed in the 3rd busy cycle of a DIV
//    -> busy=0, hi=lo=0 asynchronously; no late commit after release.
//  MTLO 0xDEADBEEF while IDLE
//    -> lo=0xDEADBEEF next cycle; busy and stall stay 0.

Source files
------------

// File: rtl/md_unit_ctrl.sv
// Multiply/divide sequencer for the E stage: owns HI/LO, models the multi-cycle
// latency of MULT/DIV and requests a D-stage stall while the unit is occupied.
module md_unit_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        md_in_d,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      hi_nx_q, hi_nx_d, lo_nx_q, lo_nx_d;

  // Returns {hi, lo}; a zero divisor returns the current HI/LO so the commit is a no-op.
  function automatic logic [63:0] md_calc(input logic [2:0]  f_op,
                                          input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] hi_cur,
                                          input logic [31:0] lo_cur);
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] sa, sb, q_s, r_s;
    logic        [63:0] res;
    sa     = $signed(a);
    sb     = $signed(b);
    prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u = {32'd0, a} * {32'd0, b};
    q_s    = '0;
    r_s    = '0;
    res    = {hi_cur, lo_cur};
    case (f_op)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_DIV: begin
        if (b != 32'd0) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            res = {32'd0, 32'h8000_0000};
          end else begin
            q_s = sa / sb;
            r_s = sa % sb;
            res = {r_s, q_s};
          end
        end
      end
      OP_DIVU: begin
        if (b != 32'd0) res = {a % b, a / b};
      end
      default: res = {hi_cur, lo_cur};
    endcase
    return res;
  endfunction

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      hi_nx_q <= '0;
      lo_nx_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      hi_nx_q <= hi_nx_d;
      lo_nx_q <= lo_nx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    hi_nx_d = hi_nx_q;
    lo_nx_d = lo_nx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              {hi_nx_d, lo_nx_d} = md_calc(op, src_a, src_b, hi_q, lo_q);
              cnt_d   = CNT_W'(MULT_CYCLES);
              state_d = RUN;
            end
            OP_DIV, OP_DIVU: begin
              {hi_nx_d, lo_nx_d} = md_calc(op, src_a, src_b, hi_q, lo_q);
              cnt_d   = CNT_W'(DIV_CYCLES);
              state_d = RUN;
            end
            OP_MTHI: hi_d = src_a;
            OP_MTLO: lo_d = src_a;
            default: ;
          endcase
        end
      end
      RUN: begin
        // Starts seen here are dropped; the stall output keeps D from issuing them.
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = hi_nx_q;
          lo_d    = lo_nx_q;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q == RUN);
    stall = md_in_d & ((state_q == RUN) | (start & (op <= OP_DIVU)));
    hi    = hi_q;
    lo    = lo_q;
  end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Scoreboard bench for md_unit_ctrl: directed commands push expected HI/LO and
// busy length; a negedge monitor checks them when busy falls.
module tb_md_unit_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, md_in_d;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        busy, stall;
  logic [31:0] hi, lo;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          len;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .src_a   (src_a),
    .src_b   (src_b),
    .md_in_d (md_in_d),
    .busy    (busy),
    .stall   (stall),
    .hi      (hi),
    .lo      (lo)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic wait_idle();
    int i = 0;
    while (busy && i < 40) begin
      @(posedge clk); #1;
      i++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
    @(negedge clk); #1;
  endtask

  task automatic md_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input int len);
    exp_q.push_back(exp_t'{eh, el, len});
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();
  endtask

  task automatic mt(input logic [2:0] o, input logic [31:0] a);
    op = o; src_a = a; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    fork
      begin : monitor
        logic bprev;
        int   rlen;
        exp_t e;
        bprev = 1'b0;
        rlen  = 0;
        forever begin
          @(negedge clk);
          if (!reset) begin
            bprev = 1'b0;
            rlen  = 0;
          end else begin
            if (busy) rlen++;
            if (bprev && !busy) begin
              if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_unexpected: busy fell with no pending entry, hi=%h lo=%h", hi, lo);
              end else begin
                e = exp_q.pop_front();
                chk("sb_hi", hi, e.hi);
                chk("sb_lo", lo, e.lo);
                chk("sb_busy_len", rlen, e.len);
              end
              rlen = 0;
            end
            bprev = busy;
          end
        end
      end
      begin : stim
        reset = 1'b0; start = 1'b0; op = '0; src_a = '0; src_b = '0; md_in_d = 1'b1;
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        @(negedge clk); #1 reset = 1'b1;
        md_in_d = 1'b0;
        @(negedge clk); #1;

        md_op(3'd0, 32'd3,         32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 5);
        md_op(3'd1, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE, 5);
        md_op(3'd3, 32'd7,         32'd2,         32'd1,         32'd3,         10);
        md_op(3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
        md_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 10);
        md_op(3'd2, 32'd100,       32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFF2, 10);

        // Divide by zero keeps preloaded HI/LO.
        mt(3'd4, 32'h11);
        mt(3'd5, 32'h22);
        chk("mthi_hi", hi, 32'h11);
        chk("mtlo_lo", lo, 32'h22);
        md_op(3'd2, 32'd5, 32'd0, 32'h11, 32'h22, 10);

        // MTLO with an md op waiting in D: no busy, no stall.
        md_in_d = 1'b1;
        op = 3'd5; src_a = 32'hDEAD_BEEF; start = 1'b1;
        #1 chk("mtlo_stall_start", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        chk("mtlo_lo_dead", lo, 32'hDEAD_BEEF);
        chk("mtlo_hi_keep", hi, 32'h11);
        chk("mtlo_busy", {31'd0, busy}, 32'd0);
        chk("mtlo_stall", {31'd0, stall}, 32'd0);

        // Reserved op is ignored.
        op = 3'd6; src_a = 32'h5; src_b = 32'h5; start = 1'b1;
        #1 chk("rsv_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("rsv_busy", {31'd0, busy}, 32'd0);
        chk("rsv_hi", hi, 32'h11);
        chk("rsv_lo", lo, 32'hDEAD_BEEF);

        // Stall window with md_in_d held, plus an ignored start mid-run.
        @(negedge clk); #1;
        exp_q.push_back(exp_t'{32'h1, 32'h0001_0000, 5});
        op = 3'd0; src_a = 32'h0001_0001; src_b = 32'h0001_0000; start = 1'b1;
        #1 chk("stall_start_cycle", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
          chk("stall_busy_cycle", {31'd0, stall}, 32'd1);
          chk("busy_cycle", {31'd0, busy}, 32'd1);
          if (i == 1) begin
            op = 3'd1; src_a = 32'hFFFF_FFFF; src_b = 32'hFFFF_FFFF; start = 1'b1;
          end else begin
            start = 1'b0;
          end
          @(posedge clk); #1;
        end
        chk("stall_after", {31'd0, stall}, 32'd0);
        chk("busy_after", {31'd0, busy}, 32'd0);
        @(negedge clk); #1;
        md_in_d = 1'b0;

        // Reset in the third busy cycle of a DIV aborts it with no late commit.
        op = 3'd2; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0;
        #1;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_hi", hi, 32'd0);
        chk("arst_lo", lo, 32'd0);
        @(negedge clk); #1 reset = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        chk("post_rst_hi", hi, 32'd0);
        chk("post_rst_lo", lo, 32'd0);

        chk("sb_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
      end
    join
  end

endmodule
